// File: rtl/mm_seq.sv
// Load/compute sequencer for a bit-serial systolic matrix multiply: streams activations,
// then weights LSB-first, runs the array for K*P cycles and waits for its completion flag.
module mm_seq #(
    parameter int N        = 2,
    parameter int K        = 2,
    parameter int MAX_PREC = 8,
    parameter int TIMEOUT  = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [3:0]                        precision,
    input  logic                              mm_done,
    output logic                              wr_en_act,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] act_k,
    output logic                              wr_en_w,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] w_k,
    output logic [3:0]                        w_bit,
    output logic                              active,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PM = (MAX_PREC > 15) ? 15 : MAX_PREC;

    localparam logic [3:0]    PREC_MAX = 4'(PM);
    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(1);

    // The array dimension does not change the sequence; an empty block marks an illegal size.
    if (N < 1) begin : g_invalid_n
    end

    typedef enum logic [2:0] {
        IDLE, LOAD_ACT, GAP, LOAD_W, SETTLE, RUN, WAIT_DONE, FINISH
    } state_t;

    state_t        state, state_n;
    logic [3:0]    p_reg, p_n;
    logic [KW-1:0] k_cnt, k_n;
    logic [3:0]    b_cnt, b_n;
    logic [TW-1:0] t_cnt, t_n;
    logic          err_n;
    logic          mm_done_p0, mm_done_p1;
    logic          done_rise;

    assign done_rise = mm_done_p0 & ~mm_done_p1;

    always_comb begin
        state_n = state;
        p_n     = p_reg;
        k_n     = k_cnt;
        b_n     = b_cnt;
        t_n     = t_cnt;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                k_n = '0;
                b_n = '0;
                t_n = '0;
                if (start) begin
                    if (precision != 4'd0 && precision <= PREC_MAX) begin
                        p_n     = precision;
                        state_n = LOAD_ACT;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            LOAD_ACT: begin
                if (k_cnt == K_LAST) begin
                    k_n     = '0;
                    state_n = GAP;
                end else begin
                    k_n = k_cnt + 1'b1;
                end
            end
            GAP: state_n = LOAD_W;
            // Weight load and compute share the same K x P nested count.
            LOAD_W, RUN: begin
                if (b_cnt == p_reg - 4'd1) begin
                    b_n = '0;
                    if (k_cnt == K_LAST) begin
                        k_n     = '0;
                        state_n = (state == LOAD_W) ? SETTLE : WAIT_DONE;
                    end else begin
                        k_n = k_cnt + 1'b1;
                    end
                end else begin
                    b_n = b_cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (t_cnt == SETTLE_LAST) begin
                    t_n     = '0;
                    state_n = RUN;
                end else begin
                    t_n = t_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    t_n     = '0;
                    state_n = FINISH;
                end else if (t_cnt == T_LAST) begin
                    t_n     = '0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    t_n = t_cnt + 1'b1;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state just entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            p_reg      <= '0;
            k_cnt      <= '0;
            b_cnt      <= '0;
            t_cnt      <= '0;
            mm_done_p0 <= 1'b0;
            mm_done_p1 <= 1'b0;
            wr_en_act  <= 1'b0;
            act_k      <= '0;
            wr_en_w    <= 1'b0;
            w_k        <= '0;
            w_bit      <= '0;
            active     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            p_reg      <= p_n;
            k_cnt      <= k_n;
            b_cnt      <= b_n;
            t_cnt      <= t_n;
            mm_done_p0 <= mm_done;
            mm_done_p1 <= mm_done_p0;
            wr_en_act  <= (state_n == LOAD_ACT);
            act_k      <= (state_n == LOAD_ACT) ? k_n : '0;
            wr_en_w    <= (state_n == LOAD_W);
            w_k        <= (state_n == LOAD_W) ? k_n : '0;
            w_bit      <= (state_n == LOAD_W) ? b_n : '0;
            active     <= (state_n == RUN);
            busy       <= (state_n != IDLE);
            done       <= (state_n == FINISH);
            err        <= err_n;
        end
    end

endmodule

// File: tb/tb_mm_seq.sv
// Scoreboard bench for mm_seq: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_mm_seq;

    localparam int K    = 2;
    localparam int TOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] precision;
    logic       mm_done;
    logic       wr_en_act;
    logic [0:0] act_k;
    logic       wr_en_w;
    logic [0:0] w_k;
    logic [3:0] w_bit;
    logic       active;
    logic       busy;
    logic       done;
    logic       err;

    mm_seq #(.N(2), .K(K), .MAX_PREC(8), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .precision(precision), .mm_done(mm_done),
        .wr_en_act(wr_en_act), .act_k(act_k), .wr_en_w(wr_en_w), .w_k(w_k), .w_bit(w_bit),
        .active(active), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    // Field order: wr_en_act, act_k, wr_en_w, w_k, w_bit[3:0], active, busy, done, err
    function automatic logic [11:0] mk(int a, int ak, int w, int wk, int wb,
                                       int act, int bz, int dn, int er);
        logic [11:0] v;
        v = {a[0], ak[0], w[0], wk[0], wb[3:0], act[0], bz[0], dn[0], er[0]};
        return v;
    endfunction

    task automatic push(input int c, input logic [11:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int c0, input int n, input string tag);
        for (int i = 0; i < n; i++) push(c0 + i, 12'd0, tag);
    endtask

    // Relative cycle c (1 = cycle after the edge that sampled start) maps to cyc e0+c-1.
    task automatic push_seq(input int e0, input int p, input bit to, input int upto,
                            input string tag);
        int w0, last, i;
        logic [11:0] v;
        w0   = 6 + 4 * p;
        last = to ? (w0 + TOUT) : (w0 + 5);
        for (int c = 1; c <= last && c <= upto; c++) begin
            if (c <= 2)
                v = mk(1, c - 1, 0, 0, 0, 0, 1, 0, 0);
            else if (c == 3)
                v = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
            else if (c <= 3 + 2 * p) begin
                i = c - 4;
                v = mk(0, 0, 1, i / p, i % p, 0, 1, 0, 0);
            end else if (c <= 5 + 2 * p)
                v = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
            else if (c <= 5 + 4 * p)
                v = mk(0, 0, 0, 0, 0, 1, 1, 0, 0);
            else if (c == last && to)
                v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
            else if (c == last)
                v = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
            else
                v = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
            push(e0 + c - 1, v, tag);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] got;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            got = {wr_en_act, act_k, wr_en_w, w_k, w_bit, active, busy, done, err};
            n_vec++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cyc %0d reached at cyc %0d", e.tag, e.cyc, cyc);
            end else if (got !== e.v) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: outputs %b, required %b (act,ak,w,wk,wbit4,run,busy,done,err)",
                         e.tag, cyc, got, e.v);
            end
        end
    end

    // Successful run with mm_done rising so it is sampled at relative edge 9+4p.
    task automatic run_ok(input int p, input string tag);
        int e0, d;
        e0 = cyc + 1;
        d  = 9 + 4 * p;
        push_seq(e0, p, 1'b0, 999, tag);
        push_idle(e0 + 11 + 4 * p, 1, {tag, "_idle"});
        precision = 4'(p);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(e0 + 9);
        start     = 1'b1;
        precision = 4'd0;
        @(negedge clk);
        start     = 1'b0;
        precision = 4'(p);
        wait_cyc(e0 + d - 1);
        mm_done = 1'b1;
        wait_cyc(e0 + 11 + 4 * p);
        mm_done = 1'b0;
    endtask

    initial begin
        int e0;
        rst       = 1'b1;
        start     = 1'b0;
        mm_done   = 1'b0;
        precision = 4'd0;
        repeat (3) @(negedge clk);
        push_idle(cyc + 1, 2, "reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_ok(4, "nominal");

        for (int j = 0; j < 2; j++) begin
            e0 = cyc + 1;
            push(e0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "bad_prec_err");
            push_idle(e0 + 1, 2, "bad_prec_idle");
            precision = (j == 0) ? 4'd0 : 4'd9;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_cyc(e0 + 2);
        end

        run_ok(1, "prec1");

        e0 = cyc + 1;
        push_seq(e0, 4, 1'b1, 999, "timeout");
        push_idle(e0 + 38, 1, "timeout_idle");
        precision = 4'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(e0 + 4);
        mm_done = 1'b1;
        wait_cyc(e0 + 38);
        mm_done = 1'b0;

        e0 = cyc + 1;
        push_seq(e0, 4, 1'b0, 8, "rst_mid");
        push_idle(e0 + 8, 3, "rst_clear");
        precision = 4'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(e0 + 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(e0 + 10);
        run_ok(4, "after_rst");

        e0 = cyc + 1;
        push_seq(e0, 4, 1'b0, 999, "held1");
        push_idle(e0 + 27, 1, "held_gap");
        push_seq(e0 + 28, 4, 1'b0, 999, "held2");
        push_idle(e0 + 55, 2, "held_end");
        precision = 4'd4;
        start     = 1'b1;
        wait_cyc(e0 + 24);
        mm_done = 1'b1;
        wait_cyc(e0 + 27);
        mm_done = 1'b0;
        wait_cyc(e0 + 52);
        mm_done = 1'b1;
        wait_cyc(e0 + 55);
        mm_done = 1'b0;
        start   = 1'b0;

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

endmodule
